bist_mem_sequencer: RTL and testbench
=====================================

Name: bist_mem_sequencer

Overview:
- Downstream of the BIST pattern decoder.
- Takes the decoder's 8-bit test pattern and expected value, and sweeps one march element across a synchronous single-port RAM.
- Per address: optional read-and-compare, then write.
- Sweeps ascending or descending, accumulates pass/fail status, and signals element completion back to the march controller.

Parameters:
- ADDR_W, 4, RAM address width; element covers 2**ADDR_W addresses.
- DATA_W, 8, RAM/pattern data width.
- ERR_CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk_march  in  1  march clock
- rst  in  1  reset
- start  in  1  one-cycle request to run one element
- data_t  in  DATA_W  write pattern from decoder
- expect_t  in  DATA_W  expected read-back value
- dir_down  in  1  1 = descending address order
- do_read  in  1  1 = read-compare before each write
- clr_err  in  1  clears fail/err_cnt/first_fail_addr
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_re
- busy  out  1  element in progress
- done  out  1  one-cycle pulse, element complete
- fail  out  1  sticky mismatch flag
- err_cnt  out  ERR_CNT_W  saturating mismatch count
- first_fail_addr  out  ADDR_W  address of first mismatch since clear

Behaviour:
- Reset rst, asynchronous, active-high; clock clk_march. All state is reset by rst.
- Reset values:
  - state IDLE.
  - mem_addr, mem_wdata, err_cnt, first_fail_addr = 0.
  - mem_we, mem_re, busy, done, fail = 0.
- Reset mid-element aborts at once with no done pulse. The next start begins from the first address.
- States: IDLE, READ, CMP, WRITE, DONE. Outputs are Moore/registered.
- IDLE:
  - start=1 latches data_t, expect_t, dir_down, do_read.
  - Address is set to 0 (up) or 2**ADDR_W-1 (down).
  - Next state is READ if do_read, else WRITE.
- READ: mem_re=1 -> CMP.
- CMP:
  - Compare mem_rdata against the latched expect.
  - On mismatch: fail<=1 and err_cnt+=1, saturating at all-ones.
  - first_fail_addr<=mem_addr only if fail was 0.
  - Next state WRITE.
- WRITE:
  - mem_we=1, mem_wdata = latched pattern.
  - If the address is the last one (15 up / 0 down for ADDR_W=4), go to DONE.
  - Otherwise step the address by ±1 (no wrap) and go to READ or WRITE.
- DONE: done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- Latency from the start-sampling edge to the edge entering DONE:
  - 2**ADDR_W cycles write-only.
  - 3*2**ADDR_W cycles with read.
- start while busy is ignored. Input changes while busy are ignored because the values are latched.
- clr_err in the same cycle as a CMP mismatch: the mismatch wins (fail=1, err_cnt=1, first_fail_addr=current address).
- clr_err is honoured in any state and does not disturb the sweep.

Optional Feature:
- Macro BIST_SEQ_DIAG_EN.
- Defined:
  - Adds output fail_bits (out, DATA_W): sticky OR of (mem_rdata ^ expect) over all CMP cycles.
  - Reset and clr_err set it to 0.
  - On a clr_err/mismatch collision it takes the current XOR.
- Undefined: the port and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package bist_pkg:
  - enum seq_state_t {IDLE, READ, CMP, WRITE, DONE}.
  - Default-width localparams.
  - Direction constants DIR_UP=0, DIR_DOWN=1.
- Sub-module bist_cmp holds the comparator plus the fail/err_cnt/first_fail_addr/fail_bits registers.
  - Inputs: cmp_en, rdata, expect, addr, clr_err.
  - The FSM and address counter stay in the top.

Test Plan:
- Write-only ascending: start with data_t=8'hAA, do_read=0, dir_down=0.
  - mem_we high 16 consecutive cycles at addr 0..15 with wdata 8'hAA.
  - done pulses once, 16 edges after start; busy low afterwards.
- Read+write descending, RAM preloaded 8'hAA: expect_t=8'hAA, data_t=8'h55.
  - READ/CMP/WRITE sequence at addr 15..0.
  - done 48 edges after start; fail=0, err_cnt=0; RAM all 8'h55.
- Fault: RAM addr 5 returns 8'hAB, ascending, expect 8'hAA.
  - fail=1, err_cnt=1, first_fail_addr=5.
  - fail_bits=8'h01 with BIST_SEQ_DIAG_EN.
  - Sweep still completes.
- Saturation: ERR_CNT_W=2, RAM all 8'hFF, expect 8'h00.
  - err_cnt reaches 3 and holds; first_fail_addr=0.
- rst pulsed while at addr 7 of an ascending read element.
  - All outputs immediately at reset values, no done.
  - A new start sweeps from addr 0.
- start re-asserted while busy: no restart, single done.
- clr_err coincident with the mismatch at addr 9: err_cnt=1, first_fail_addr=9.

Source files
------------

// File: rtl/bist_mem_sequencer_pkg.sv
// rtl/bist_mem_sequencer_pkg.sv - shared types and default widths for the BIST march sequencer
package bist_pkg;

   localparam int DEF_ADDR_W    = 4;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ERR_CNT_W = 8;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CMP,
      WRITE,
      DONE
   } seq_state_t;

endpackage

// File: rtl/bist_mem_sequencer_if.sv
// rtl/bist_mem_sequencer_if.sv - single-port RAM bus between the march sequencer and the array under test
interface bist_mem_sequencer_if
   import bist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              we;
   logic              re;
   logic [DATA_W-1:0] rdata;

   modport master (output addr, output wdata, output we, output re, input rdata);
   modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/bist_mem_sequencer_cmp.sv
// rtl/bist_mem_sequencer_cmp.sv - bist_cmp: read-back comparator and sticky fail/err_cnt/first_fail_addr status
// Optional BIST_SEQ_DIAG_EN adds the fail_bits diagnostic register.
module bist_cmp
   import bist_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ERR_CNT_W = DEF_ERR_CNT_W
)(
   input  logic                 clk_march,
   input  logic                 rst,
   input  logic                 cmp_en,
   input  logic [DATA_W-1:0]    rdata,
   input  logic [DATA_W-1:0]    expect_val,
   input  logic [ADDR_W-1:0]    addr,
   input  logic                 clr_err,
   output logic                 fail,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ADDR_W-1:0]    first_fail_addr
`ifdef BIST_SEQ_DIAG_EN
   ,
   output logic [DATA_W-1:0]    fail_bits
`endif
);
   localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   logic [DATA_W-1:0] diff;
   logic              mismatch;

   assign diff     = rdata ^ expect_val;
   assign mismatch = cmp_en && (diff != '0);

   // A mismatch takes priority over a simultaneous clear: the clear empties history, the mismatch is logged fresh.
   always_ff @(posedge clk_march or posedge rst) begin
      if (rst) begin
         fail            <= 1'b0;
         err_cnt         <= '0;
         first_fail_addr <= '0;
`ifdef BIST_SEQ_DIAG_EN
         fail_bits       <= '0;
`endif
      end else if (mismatch) begin
         fail    <= 1'b1;
         err_cnt <= clr_err ? ERR_ONE : ((err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_ONE);
         if (clr_err || !fail)
            first_fail_addr <= addr;
`ifdef BIST_SEQ_DIAG_EN
         fail_bits <= clr_err ? diff : (fail_bits | diff);
`endif
      end else if (clr_err) begin
         fail            <= 1'b0;
         err_cnt         <= '0;
         first_fail_addr <= '0;
`ifdef BIST_SEQ_DIAG_EN
         fail_bits       <= '0;
`endif
      end
   end

endmodule

// File: rtl/bist_mem_sequencer.sv
// rtl/bist_mem_sequencer.sv - sweeps one march element (read-compare then write) across a single-port RAM
// Optional BIST_SEQ_DIAG_EN exposes fail_bits from the comparator.
module bist_mem_sequencer
   import bist_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ERR_CNT_W = DEF_ERR_CNT_W
)(
   input  logic                 clk_march,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_W-1:0]    data_t,
   input  logic [DATA_W-1:0]    expect_t,
   input  logic                 dir_down,
   input  logic                 do_read,
   input  logic                 clr_err,
   bist_mem_sequencer_if.master mem,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ADDR_W-1:0]    first_fail_addr
`ifdef BIST_SEQ_DIAG_EN
   ,
   output logic [DATA_W-1:0]    fail_bits
`endif
);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

   seq_state_t        state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              re_q;
   logic [DATA_W-1:0] pat_q;
   logic [DATA_W-1:0] exp_q;
   logic              dir_q;
   logic              rd_q;
   logic              last_addr;

   assign last_addr = (dir_q == DIR_DOWN) ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_TOP);

   assign mem.addr  = addr_q;
   assign mem.wdata = wdata_q;
   assign mem.we    = we_q;
   assign mem.re    = re_q;

   // Outputs are loaded on the transition into the state that owns them, so they are valid for that whole state.
   always_ff @(posedge clk_march or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pat_q   <= '0;
         exp_q   <= '0;
         dir_q   <= DIR_UP;
         rd_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  pat_q  <= data_t;
                  exp_q  <= expect_t;
                  dir_q  <= dir_down;
                  rd_q   <= do_read;
                  addr_q <= (dir_down == DIR_DOWN) ? ADDR_TOP : ADDR_ZERO;
                  busy   <= 1'b1;
                  if (do_read) begin
                     re_q  <= 1'b1;
                     state <= READ;
                  end else begin
                     we_q    <= 1'b1;
                     wdata_q <= data_t;
                     state   <= WRITE;
                  end
               end
            end
            READ: begin
               re_q  <= 1'b0;
               state <= CMP;
            end
            CMP: begin
               we_q    <= 1'b1;
               wdata_q <= pat_q;
               state   <= WRITE;
            end
            WRITE: begin
               we_q <= 1'b0;
               if (last_addr) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  addr_q <= (dir_q == DIR_DOWN) ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                  if (rd_q) begin
                     re_q  <= 1'b1;
                     state <= READ;
                  end else begin
                     we_q    <= 1'b1;
                     wdata_q <= pat_q;
                     state   <= WRITE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   bist_cmp #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .ERR_CNT_W (ERR_CNT_W)
   ) u_cmp (
      .clk_march       (clk_march),
      .rst             (rst),
      .cmp_en          (state == CMP),
      .rdata           (mem.rdata),
      .expect_val      (exp_q),
      .addr            (addr_q),
      .clr_err         (clr_err),
      .fail            (fail),
      .err_cnt         (err_cnt),
      .first_fail_addr (first_fail_addr)
`ifdef BIST_SEQ_DIAG_EN
      ,
      .fail_bits       (fail_bits)
`endif
   );

endmodule

// File: tb/tb_bist_mem_sequencer.sv
// tb/tb_bist_mem_sequencer.sv - scoreboard bench for bist_mem_sequencer (checks fail_bits when BIST_SEQ_DIAG_EN is set)
module tb_bist_mem_sequencer;

   logic clk_march = 1'b0;
   logic rst;
   always #5 clk_march = ~clk_march;

   logic       start, start2, dir_down, do_read, clr_err;
   logic [7:0] data_t, expect_t;
   logic       busy, done, fail, busy2, done2, fail2;
   logic [7:0] err_cnt;
   logic [1:0] err_cnt2;
   logic [3:0] first_fail_addr, first_fail_addr2;
`ifdef BIST_SEQ_DIAG_EN
   logic [7:0] fail_bits, fail_bits2;
`endif

   bist_mem_sequencer_if #(.ADDR_W(4), .DATA_W(8)) mbus ();
   bist_mem_sequencer_if #(.ADDR_W(4), .DATA_W(8)) sbus ();

   bist_mem_sequencer #(.ADDR_W(4), .DATA_W(8), .ERR_CNT_W(8)) dut (
      .clk_march(clk_march), .rst(rst), .start(start), .data_t(data_t), .expect_t(expect_t),
      .dir_down(dir_down), .do_read(do_read), .clr_err(clr_err), .mem(mbus),
      .busy(busy), .done(done), .fail(fail), .err_cnt(err_cnt), .first_fail_addr(first_fail_addr)
`ifdef BIST_SEQ_DIAG_EN
      , .fail_bits(fail_bits)
`endif
   );

   bist_mem_sequencer #(.ADDR_W(4), .DATA_W(8), .ERR_CNT_W(2)) dut_sat (
      .clk_march(clk_march), .rst(rst), .start(start2), .data_t(data_t), .expect_t(expect_t),
      .dir_down(dir_down), .do_read(do_read), .clr_err(clr_err), .mem(sbus),
      .busy(busy2), .done(done2), .fail(fail2), .err_cnt(err_cnt2), .first_fail_addr(first_fail_addr2)
`ifdef BIST_SEQ_DIAG_EN
      , .fail_bits(fail_bits2)
`endif
   );

   // RAM models: one-cycle read latency, optional stuck read value at one address
   logic [7:0] ram [16];
   logic [7:0] ram2 [16];
   logic       fill_req, fault_on;
   logic [7:0] fill_val, fault_val;
   logic [3:0] fault_addr;

   always @(posedge clk_march) begin
      if (fill_req) begin
         for (int i = 0; i < 16; i++) begin
            ram[i]  <= fill_val;
            ram2[i] <= fill_val;
         end
      end else begin
         if (mbus.we) ram[mbus.addr] <= mbus.wdata;
         if (sbus.we) ram2[sbus.addr] <= sbus.wdata;
      end
      if (mbus.re) mbus.rdata <= (fault_on && mbus.addr == fault_addr) ? fault_val : ram[mbus.addr];
      if (sbus.re) sbus.rdata <= ram2[sbus.addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] exp_w[$], obs_w[$];
   logic [3:0]  exp_r[$], obs_r[$];
   int          obs_wc[$];

   task automatic preload(input logic [7:0] v);
      @(negedge clk_march);
      fill_val = v;
      fill_req = 1'b1;
      @(negedge clk_march);
      fill_req = 1'b0;
   endtask

   task automatic kick(input logic [7:0] d, input logic [7:0] e, input logic dn, input logic rd);
      logic [3:0] a;
      exp_w.delete();
      exp_r.delete();
      @(negedge clk_march);
      data_t = d; expect_t = e; dir_down = dn; do_read = rd; start = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = dn ? 4'(15 - i) : 4'(i);
         exp_w.push_back({a, d});
         if (rd) exp_r.push_back(a);
      end
   endtask

   // Collects bus activity until the element ends; inputs are scrambled after the start edge.
   task automatic run_elem(input int budget, input int poke_at, input int clr_addr,
                           output int lat, output int ndone);
      lat = -1; ndone = 0;
      obs_w.delete(); obs_wc.delete(); obs_r.delete();
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk_march);
         start = (c == poke_at);
         data_t = 8'($urandom); expect_t = 8'($urandom);
         dir_down = 1'($urandom_range(0, 1)); do_read = 1'($urandom_range(0, 1));
         clr_err = (clr_addr >= 0) && busy && !mbus.re && !mbus.we && (mbus.addr == clr_addr[3:0]);
         if (mbus.we) begin obs_w.push_back({mbus.addr, mbus.wdata}); obs_wc.push_back(c); end
         if (mbus.re) obs_r.push_back(mbus.addr);
         if (done) begin ndone++; if (lat < 0) lat = c - 1; end
         if (ndone > 0 && !busy) break;
      end
      start = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_march);
      n_cmp++; if ({mbus.addr, mbus.wdata, mbus.we, mbus.re} !== 14'h0) begin n_bad++;
         $display("FAIL reset_bus: got %h want 0", {mbus.addr, mbus.wdata, mbus.we, mbus.re}); end
      n_cmp++; if ({busy, done, fail, err_cnt, first_fail_addr} !== 15'h0) begin n_bad++;
         $display("FAIL reset_status: got %h want 0", {busy, done, fail, err_cnt, first_fail_addr}); end
      n_cmp++; if ({busy2, done2, fail2, err_cnt2, first_fail_addr2} !== 9'h0) begin n_bad++;
         $display("FAIL reset_status_sat: got %h want 0", {busy2, done2, fail2, err_cnt2, first_fail_addr2}); end
      @(negedge clk_march);
      rst = 1'b0;
   endtask

   task automatic test_write_up();
      int lat, nd;
      logic [11:0] e;
      preload(8'h00);
      kick(8'hAA, 8'h00, 1'b0, 1'b0);
      run_elem(60, -1, -1, lat, nd);
      n_cmp++; if (lat != 16) begin n_bad++; $display("FAIL wr_up_latency: got %0d want 16", lat); end
      n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL wr_up_done_count: got %0d want 1", nd); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_up_busy_after: got %b want 0", busy); end
      n_cmp++; if (obs_w.size() != 16) begin n_bad++; $display("FAIL wr_up_writes: got %0d want 16", obs_w.size()); end
      foreach (obs_w[i]) begin
         e = exp_w.pop_front();
         n_cmp++; if (obs_w[i] !== e || obs_wc[i] != i + 1) begin n_bad++;
            $display("FAIL wr_up_beat%0d: got %h@%0d want %h@%0d", i, obs_w[i], obs_wc[i], e, i + 1); end
      end
   endtask

   task automatic test_rw_down();
      int lat, nd, bad_cells;
      logic [11:0] e;
      logic [3:0]  er;
      preload(8'hAA);
      kick(8'h55, 8'hAA, 1'b1, 1'b1);
      run_elem(200, -1, -1, lat, nd);
      n_cmp++; if (lat != 48) begin n_bad++; $display("FAIL rw_down_latency: got %0d want 48", lat); end
      n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL rw_down_done_count: got %0d want 1", nd); end
      n_cmp++; if ({fail, err_cnt} !== 9'h0) begin n_bad++; $display("FAIL rw_down_status: got %h want 0", {fail, err_cnt}); end
      n_cmp++; if (obs_w.size() != 16 || obs_r.size() != 16) begin n_bad++;
         $display("FAIL rw_down_counts: got %0d/%0d want 16/16", obs_w.size(), obs_r.size()); end
      foreach (obs_w[i]) begin
         e = exp_w.pop_front();
         n_cmp++; if (obs_w[i] !== e) begin n_bad++; $display("FAIL rw_down_wr%0d: got %h want %h", i, obs_w[i], e); end
      end
      foreach (obs_r[i]) begin
         er = exp_r.pop_front();
         n_cmp++; if (obs_r[i] !== er) begin n_bad++; $display("FAIL rw_down_rd%0d: got %h want %h", i, obs_r[i], er); end
      end
      bad_cells = 0;
      for (int i = 0; i < 16; i++) if (ram[i] !== 8'h55) bad_cells++;
      n_cmp++; if (bad_cells != 0) begin n_bad++; $display("FAIL rw_down_ram: got %0d bad cells want 0", bad_cells); end
   endtask

   task automatic test_fault();
      int lat, nd;
      preload(8'hAA);
      fault_on = 1'b1; fault_addr = 4'd5; fault_val = 8'hAB;
      kick(8'hAA, 8'hAA, 1'b0, 1'b1);
      run_elem(200, -1, -1, lat, nd);
      fault_on = 1'b0;
      n_cmp++; if (lat != 48 || nd != 1) begin n_bad++; $display("FAIL fault_complete: got lat %0d done %0d want 48 1", lat, nd); end
      n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL fault_fail: got %b want 1", fail); end
      n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL fault_err_cnt: got %0d want 1", err_cnt); end
      n_cmp++; if (first_fail_addr !== 4'd5) begin n_bad++; $display("FAIL fault_first_addr: got %0d want 5", first_fail_addr); end
`ifdef BIST_SEQ_DIAG_EN
      n_cmp++; if (fail_bits !== 8'h01) begin n_bad++; $display("FAIL fault_fail_bits: got %h want 01", fail_bits); end
`endif
   endtask

   task automatic test_saturation();
      int lat, nd;
      preload(8'hFF);
      @(negedge clk_march);
      data_t = 8'hFF; expect_t = 8'h00; dir_down = 1'b0; do_read = 1'b1; start2 = 1'b1;
      lat = -1; nd = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk_march);
         start2 = 1'b0;
         if (done2) begin nd++; if (lat < 0) lat = c - 1; end
         if (nd > 0 && !busy2) break;
      end
      n_cmp++; if (lat != 48) begin n_bad++; $display("FAIL sat_latency: got %0d want 48", lat); end
      n_cmp++; if (err_cnt2 !== 2'd3) begin n_bad++; $display("FAIL sat_err_cnt: got %0d want 3", err_cnt2); end
      n_cmp++; if (fail2 !== 1'b1 || first_fail_addr2 !== 4'd0) begin n_bad++;
         $display("FAIL sat_fail_addr: got %b/%0d want 1/0", fail2, first_fail_addr2); end
   endtask

   task automatic test_reset_mid();
      int lat, nd;
      bit found, seen_done;
      logic [11:0] e;
      preload(8'hAA);
      kick(8'hAA, 8'hAA, 1'b0, 1'b1);
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk_march);
         start = 1'b0;
         if (mbus.re && mbus.addr == 4'd7) found = 1;
      end
      n_cmp++; if (!found) begin n_bad++; $display("FAIL rstmid_reach_addr7: got timeout want addr 7"); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({mbus.addr, mbus.wdata, mbus.we, mbus.re, busy, done, fail, err_cnt, first_fail_addr} !== 29'h0) begin n_bad++;
         $display("FAIL rstmid_async: got %h want 0", {mbus.addr, mbus.wdata, mbus.we, mbus.re, busy, done, fail, err_cnt, first_fail_addr}); end
      seen_done = 0;
      repeat (3) begin @(negedge clk_march); if (done) seen_done = 1; end
      rst = 1'b0;
      repeat (2) begin @(negedge clk_march); if (done) seen_done = 1; end
      n_cmp++; if (seen_done) begin n_bad++; $display("FAIL rstmid_no_done: got done want none"); end
      kick(8'h5A, 8'h00, 1'b0, 1'b0);
      run_elem(60, -1, -1, lat, nd);
      n_cmp++; if (lat != 16 || nd != 1) begin n_bad++; $display("FAIL rstmid_rerun: got lat %0d done %0d want 16 1", lat, nd); end
      n_cmp++; if (obs_w.size() != 16) begin n_bad++; $display("FAIL rstmid_writes: got %0d want 16", obs_w.size()); end
      foreach (obs_w[i]) begin
         e = exp_w.pop_front();
         n_cmp++; if (obs_w[i] !== e) begin n_bad++; $display("FAIL rstmid_wr%0d: got %h want %h", i, obs_w[i], e); end
      end
   endtask

   task automatic test_back_to_back();
      int lat, nd, idle_act;
      logic [11:0] e;
      preload(8'h00);
      kick(8'h3C, 8'h00, 1'b0, 1'b0);
      run_elem(60, 5, -1, lat, nd);
      n_cmp++; if (lat != 16 || nd != 1) begin n_bad++; $display("FAIL b2b_single_done: got lat %0d done %0d want 16 1", lat, nd); end
      n_cmp++; if (obs_w.size() != 16) begin n_bad++; $display("FAIL b2b_writes: got %0d want 16", obs_w.size()); end
      foreach (obs_w[i]) begin
         e = exp_w.pop_front();
         n_cmp++; if (obs_w[i] !== e) begin n_bad++; $display("FAIL b2b_wr%0d: got %h want %h", i, obs_w[i], e); end
      end
      idle_act = 0;
      repeat (6) begin @(negedge clk_march); if (busy || mbus.we || done) idle_act++; end
      n_cmp++; if (idle_act != 0) begin n_bad++; $display("FAIL b2b_idle_after: got %0d active cycles want 0", idle_act); end
   endtask

   task automatic test_clr_collision();
      int lat, nd;
      preload(8'hAA);
      fault_on = 1'b1; fault_addr = 4'd3; fault_val = 8'hAB;
      kick(8'hAA, 8'hAA, 1'b0, 1'b1);
      run_elem(200, -1, -1, lat, nd);
      n_cmp++; if (err_cnt !== 8'd1 || first_fail_addr !== 4'd3) begin n_bad++;
         $display("FAIL clr_pre: got %0d/%0d want 1/3", err_cnt, first_fail_addr); end
      fault_addr = 4'd9; fault_val = 8'hA8;
      kick(8'hAA, 8'hAA, 1'b0, 1'b1);
      run_elem(200, -1, 9, lat, nd);
      fault_on = 1'b0;
      n_cmp++; if (lat != 48 || nd != 1) begin n_bad++; $display("FAIL clr_complete: got lat %0d done %0d want 48 1", lat, nd); end
      n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL clr_err_cnt: got %0d want 1", err_cnt); end
      n_cmp++; if (first_fail_addr !== 4'd9 || fail !== 1'b1) begin n_bad++;
         $display("FAIL clr_first_addr: got %0d/%b want 9/1", first_fail_addr, fail); end
`ifdef BIST_SEQ_DIAG_EN
      n_cmp++; if (fail_bits !== 8'h02) begin n_bad++; $display("FAIL clr_fail_bits: got %h want 02", fail_bits); end
`endif
      @(negedge clk_march); clr_err = 1'b1;
      @(negedge clk_march); clr_err = 1'b0;
      n_cmp++; if ({fail, err_cnt, first_fail_addr} !== 13'h0) begin n_bad++;
         $display("FAIL clr_idle: got %h want 0", {fail, err_cnt, first_fail_addr}); end
`ifdef BIST_SEQ_DIAG_EN
      n_cmp++; if (fail_bits !== 8'h00) begin n_bad++; $display("FAIL clr_idle_fail_bits: got %h want 00", fail_bits); end
`endif
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start2 = 1'b0; clr_err = 1'b0;
      data_t = 8'h00; expect_t = 8'h00; dir_down = 1'b0; do_read = 1'b0;
      fill_req = 1'b0; fill_val = 8'h00; fault_on = 1'b0; fault_addr = 4'd0; fault_val = 8'h00;
      test_reset();
      test_write_up();
      test_rw_down();
      test_fault();
      test_saturation();
      test_reset_mid();
      test_back_to_back();
      test_clr_collision();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
